// File: rtl/pipelined_core_param.sv
// Parametrised 4-stage (IF/ID/EX/WB) core with loadable instruction memory,
// selectable forwarding or stall interlock, run/halt control and debug ports.
module pipelined_core_param #(
    parameter int unsigned  DATA_W     = 8,
    parameter int unsigned  IMEM_DEPTH = 16,
    parameter bit           FWD_EN     = 1'b1,
    localparam int unsigned PA_W       = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [PA_W-1:0]   prog_addr,
    input  logic [7:0]        prog_data,
    input  logic              run,
    input  logic [2:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [PA_W:0]     pc_out,
    output logic              wb_valid,
    output logic [2:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [15:0]       stall_cnt,
    output logic              halted
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDI = 2'b10,
        OP_AND  = 2'b11
    } op_e;

    localparam int unsigned   RF_N   = 8;
    localparam logic [PA_W:0] PC_END = (PA_W+1)'(IMEM_DEPTH);

    logic [7:0]        imem [IMEM_DEPTH];
    logic [DATA_W-1:0] rf   [RF_N];
    logic [PA_W:0]     pc;

    logic              ifid_valid;
    logic [7:0]        ifid_instr;
    logic              idex_valid;
    op_e               idex_op;
    logic [2:0]        idex_rd;
    logic [2:0]        idex_rs;
    logic [DATA_W-1:0] idex_a;
    logic [DATA_W-1:0] idex_b;
    logic              exwb_valid;
    logic [2:0]        exwb_rd;
    logic [DATA_W-1:0] exwb_data;
    logic [15:0]       stall_q;
    logic              halted_q;

    op_e               id_op;
    logic [2:0]        id_rd;
    logic [2:0]        id_rs;
    logic              id_uses_rs;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_a;
    logic [DATA_W-1:0] id_b;
    logic              hz_rd;
    logic              hz_rs;
    logic              stall;
    logic              fetch;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [DATA_W-1:0] ex_res;

    // Decode and register read; write-through bypasses the WB write in flight
    always_comb begin
        id_op      = op_e'(ifid_instr[7:6]);
        id_rd      = ifid_instr[5:3];
        id_rs      = ifid_instr[2:0];
        id_uses_rs = (id_op != OP_ADDI);
        id_imm     = {{(DATA_W-3){ifid_instr[2]}}, ifid_instr[2:0]};
        id_a       = rf[id_rd];
        id_b       = rf[id_rs];
        if (FWD_EN && exwb_valid && (exwb_rd == id_rd)) id_a = exwb_data;
        if (FWD_EN && exwb_valid && (exwb_rd == id_rs)) id_b = exwb_data;
        if (!id_uses_rs) id_b = id_imm;
    end

    // Interlock: any source still owned by an instruction in EX or WB
    always_comb begin
        hz_rd = (idex_valid && (idex_rd == id_rd)) || (exwb_valid && (exwb_rd == id_rd));
        hz_rs = id_uses_rs &&
                ((idex_valid && (idex_rd == id_rs)) || (exwb_valid && (exwb_rd == id_rs)));
        stall = !FWD_EN && ifid_valid && (hz_rd || hz_rs);
        fetch = run && (pc < PC_END) && !stall;
    end

    // Execute with EX/WB -> EX forwarding
    always_comb begin
        ex_a = idex_a;
        ex_b = idex_b;
        if (FWD_EN && exwb_valid) begin
            if (exwb_rd == idex_rd) ex_a = exwb_data;
            if ((idex_op != OP_ADDI) && (exwb_rd == idex_rs)) ex_b = exwb_data;
        end
        ex_res = ex_a + ex_b;
        case (idex_op)
            OP_SUB:  ex_res = ex_a - ex_b;
            OP_AND:  ex_res = ex_a & ex_b;
            default: ex_res = ex_a + ex_b;
        endcase
    end

    // Instruction memory is intentionally outside reset
    always_ff @(posedge clk) begin
        if (prog_we && !run) imem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= '0;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            idex_valid <= 1'b0;
            idex_op    <= OP_ADD;
            idex_rd    <= '0;
            idex_rs    <= '0;
            idex_a     <= '0;
            idex_b     <= '0;
            exwb_valid <= 1'b0;
            exwb_rd    <= '0;
            exwb_data  <= '0;
            stall_q    <= '0;
            halted_q   <= 1'b0;
            for (int i = 0; i < RF_N; i++) rf[i] <= '0;
        end else begin
            if (!stall) begin
                ifid_valid <= fetch;
                if (fetch) begin
                    pc         <= pc + (PA_W+1)'(1);
                    ifid_instr <= imem[pc[PA_W-1:0]];
                end
            end
            idex_valid <= ifid_valid && !stall;
            idex_op    <= id_op;
            idex_rd    <= id_rd;
            idex_rs    <= id_rs;
            idex_a     <= id_a;
            idex_b     <= id_b;
            exwb_valid <= idex_valid;
            exwb_rd    <= idex_rd;
            exwb_data  <= ex_res;
            if (exwb_valid) rf[exwb_rd] <= exwb_data;
            if (stall && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
            // Sets on the edge that retires the last instruction
            if ((pc == PC_END) && !ifid_valid && !idex_valid) halted_q <= 1'b1;
        end
    end

    assign dbg_rdata = rf[dbg_raddr];
    assign pc_out    = pc;
    assign wb_valid  = exwb_valid;
    assign wb_addr   = exwb_rd;
    assign wb_data   = exwb_data;
    assign stall_cnt = stall_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_pipelined_core_param.sv
// Directed bench: one forwarding and one interlocked core share stimulus and
// are checked against hand-computed register, write-back and stall results.
module tb_pipelined_core_param;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned IMEM_DEPTH = 16;
    localparam int unsigned PA_W       = 4;

    typedef struct {
        string            name;
        logic [7:0]       p0;
        logic [7:0]       p1;
        logic [7:0]       p2;
        logic [7:0][7:0]  exp_rf;
        logic [2:0][10:0] exp_wb;
        int               exp_stall;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              prog_we;
    logic              run;
    logic [PA_W-1:0]   prog_addr;
    logic [7:0]        prog_data;
    logic [2:0]        dbg_raddr;

    logic [DATA_W-1:0] f_dbg, i_dbg, f_wbd, i_wbd;
    logic [PA_W:0]     f_pc, i_pc;
    logic              f_wbv, i_wbv, f_halted, i_halted;
    logic [2:0]        f_wba, i_wba;
    logic [15:0]       f_stall, i_stall;

    int          n_pass = 0;
    int          n_tot  = 0;
    logic [10:0] f_wbq [$];
    logic [10:0] i_wbq [$];
    int          f_pc16, f_hlt, i_pc16, i_hlt;
    vec_t        vecs [5];

    always #10 clk = ~clk;

    pipelined_core_param #(.DATA_W(DATA_W), .IMEM_DEPTH(IMEM_DEPTH), .FWD_EN(1'b1)) u_fwd (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .run(run), .dbg_raddr(dbg_raddr), .dbg_rdata(f_dbg),
        .pc_out(f_pc), .wb_valid(f_wbv), .wb_addr(f_wba), .wb_data(f_wbd),
        .stall_cnt(f_stall), .halted(f_halted)
    );

    pipelined_core_param #(.DATA_W(DATA_W), .IMEM_DEPTH(IMEM_DEPTH), .FWD_EN(1'b0)) u_ilk (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .run(run), .dbg_raddr(dbg_raddr), .dbg_rdata(i_dbg),
        .pc_out(i_pc), .wb_valid(i_wbv), .wb_addr(i_wba), .wb_data(i_wbd),
        .stall_cnt(i_stall), .halted(i_halted)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input string nm, input logic [7:0] p0, p1, p2,
                                input logic [7:0] r1, r2, r3,
                                input logic [10:0] w0, w1, w2, input int st);
        vec_t v;
        v.name      = nm;
        v.p0        = p0;
        v.p1        = p1;
        v.p2        = p2;
        v.exp_rf    = '0;
        v.exp_rf[1] = r1;
        v.exp_rf[2] = r2;
        v.exp_rf[3] = r3;
        v.exp_wb[0] = w0;
        v.exp_wb[1] = w1;
        v.exp_wb[2] = w2;
        v.exp_stall = st;
        return v;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        reset   = 1'b1;
        run     = 1'b0;
        prog_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Filler rotates r4/r5/r6 so only the program's own dependencies stall
    task automatic load_img(input logic [7:0] p0, p1, p2);
        logic [7:0] w;
        for (int a = 0; a < 16; a++) begin
            case (a)
                0:       w = p0;
                1:       w = p1;
                2:       w = p2;
                default: w = (a % 3 == 0) ? 8'h24 : ((a % 3 == 1) ? 8'h2D : 8'h36);
            endcase
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = 4'(a);
            prog_data = w;
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic check_regs(input string tag, input logic [7:0][7:0] exp);
        for (int k = 0; k < 8; k++) begin
            dbg_raddr = 3'(k);
            #1;
            chk($sformatf("%s fwd r%0d", tag, k), 32'(f_dbg), 32'(exp[k]));
            chk($sformatf("%s ilk r%0d", tag, k), 32'(i_dbg), 32'(exp[k]));
        end
    endtask

    task automatic run_and_wait(output bit ok);
        f_wbq.delete();
        i_wbq.delete();
        f_pc16 = -1; f_hlt = -1; i_pc16 = -1; i_hlt = -1;
        run = 1'b1;
        ok  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (f_wbv) f_wbq.push_back({f_wba, f_wbd});
            if (i_wbv) i_wbq.push_back({i_wba, i_wbd});
            if (f_pc16 < 0 && f_pc == 5'd16) f_pc16 = c;
            if (i_pc16 < 0 && i_pc == 5'd16) i_pc16 = c;
            if (f_hlt < 0 && f_halted) f_hlt = c;
            if (i_hlt < 0 && i_halted) i_hlt = c;
            if (f_halted && i_halted) begin
                ok = 1'b1;
                break;
            end
        end
        run = 1'b0;
    endtask

    task automatic do_row(input vec_t v);
        bit          ok;
        logic [10:0] fw, iw;
        pulse_reset();
        chk({v.name, " post-reset fwd pc"}, 32'(f_pc), 32'd0);
        chk({v.name, " post-reset ilk stall"}, 32'(i_stall), 32'd0);
        chk({v.name, " post-reset ilk halted"}, 32'(i_halted), 32'd0);
        load_img(v.p0, v.p1, v.p2);
        run_and_wait(ok);
        chk({v.name, " halt reached"}, 32'(ok), 32'd1);
        chk({v.name, " fwd halt latency"}, 32'(f_hlt - f_pc16), 32'd3);
        chk({v.name, " ilk halt latency"}, 32'(i_hlt - i_pc16), 32'd3);
        chk({v.name, " fwd wb count"}, 32'(f_wbq.size()), 32'd16);
        chk({v.name, " ilk wb count"}, 32'(i_wbq.size()), 32'd16);
        for (int j = 0; j < 3; j++) begin
            fw = (j < f_wbq.size()) ? f_wbq[j] : 11'h7FF;
            iw = (j < i_wbq.size()) ? i_wbq[j] : 11'h7FF;
            chk($sformatf("%s fwd wb%0d", v.name, j), 32'(fw), 32'(v.exp_wb[j]));
            chk($sformatf("%s ilk wb%0d", v.name, j), 32'(iw), 32'(v.exp_wb[j]));
        end
        check_regs(v.name, v.exp_rf);
        chk({v.name, " fwd stall_cnt"}, 32'(f_stall), 32'd0);
        chk({v.name, " ilk stall_cnt"}, 32'(i_stall), 32'(v.exp_stall));
        chk({v.name, " fwd pc end"}, 32'(f_pc), 32'd16);
    endtask

    initial begin
        bit ok;
        vecs[0] = mk("dep1",  8'h8B, 8'h8F, 8'h11, 8'h02, 8'h02, 8'h00,
                     {3'd1, 8'h03}, {3'd1, 8'h02}, {3'd2, 8'h02}, 4);
        vecs[1] = mk("wrap",  8'h9C, 8'h1B, 8'hDB, 8'h00, 8'h00, 8'hF8,
                     {3'd3, 8'hFC}, {3'd3, 8'hF8}, {3'd3, 8'hF8}, 4);
        vecs[2] = mk("sub",   8'h8A, 8'h93, 8'h4A, 8'hFF, 8'h03, 8'h00,
                     {3'd1, 8'h02}, {3'd2, 8'h03}, {3'd1, 8'hFF}, 2);
        vecs[3] = mk("dist2", 8'h8A, 8'h9B, 8'h11, 8'h02, 8'h02, 8'h03,
                     {3'd1, 8'h02}, {3'd3, 8'h03}, {3'd2, 8'h02}, 1);
        vecs[4] = mk("and",   8'h8B, 8'h96, 8'hCA, 8'h02, 8'hFE, 8'h00,
                     {3'd1, 8'h03}, {3'd2, 8'hFE}, {3'd1, 8'h02}, 2);

        reset = 1'b1; run = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0; dbg_raddr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("reset fwd pc", 32'(f_pc), 32'd0);
        chk("reset ilk pc", 32'(i_pc), 32'd0);
        chk("reset fwd wb_valid", 32'(f_wbv), 32'd0);
        chk("reset fwd wb_addr", 32'(f_wba), 32'd0);
        chk("reset fwd wb_data", 32'(f_wbd), 32'd0);
        chk("reset ilk stall", 32'(i_stall), 32'd0);
        chk("reset fwd halted", 32'(f_halted), 32'd0);
        check_regs("reset", '0);

        for (int r = 0; r < 5; r++) do_row(vecs[r]);

        // Pause after two fetches; in-flight work drains, then resume
        pulse_reset();
        load_img(8'h8B, 8'h8F, 8'h11);
        run = 1'b1;
        repeat (2) @(negedge clk);
        run = 1'b0;
        chk("pause fwd pc", 32'(f_pc), 32'd2);
        chk("pause ilk pc", 32'(i_pc), 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("pause fwd pc hold %0d", c), 32'(f_pc), 32'd2);
            chk($sformatf("pause ilk pc hold %0d", c), 32'(i_pc), 32'd2);
        end
        dbg_raddr = 3'd1;
        #1;
        chk("pause fwd r1 drained", 32'(f_dbg), 32'h02);
        chk("pause ilk r1 drained", 32'(i_dbg), 32'h02);
        @(negedge clk);
        run       = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = 8'hFF;
        @(negedge clk);
        prog_we = 1'b0;
        run_and_wait(ok);
        chk("pause halt reached", 32'(ok), 32'd1);
        check_regs("pause", vecs[0].exp_rf);
        chk("pause fwd stall_cnt", 32'(f_stall), 32'd0);
        chk("pause ilk stall_cnt", 32'(i_stall), 32'd2);

        // Async reset two cycles into a run
        pulse_reset();
        run = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        #1;
        chk("midreset fwd pc", 32'(f_pc), 32'd0);
        chk("midreset ilk pc", 32'(i_pc), 32'd0);
        chk("midreset fwd wb_valid", 32'(f_wbv), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check_regs("midreset", '0);

        // Async reset with a write pending in EX/WB; it must not commit
        @(negedge clk);
        run = 1'b1;
        repeat (3) @(negedge clk);
        chk("wbreset fwd wb_valid before", 32'(f_wbv), 32'd1);
        chk("wbreset ilk wb_valid before", 32'(i_wbv), 32'd1);
        reset = 1'b1;
        run   = 1'b0;
        #1;
        chk("wbreset fwd wb_valid", 32'(f_wbv), 32'd0);
        chk("wbreset ilk wb_valid", 32'(i_wbv), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check_regs("wbreset", '0);

        // Rerun without reloading: imem survives reset, earlier write while running ignored
        @(negedge clk);
        run_and_wait(ok);
        chk("rerun halt reached", 32'(ok), 32'd1);
        check_regs("rerun", vecs[0].exp_rf);
        chk("rerun fwd stall_cnt", 32'(f_stall), 32'd0);
        chk("rerun ilk stall_cnt", 32'(i_stall), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
